// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP word and PC constants.
package mips_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INSN_NOP         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boot delay, sequential fetch, stalls and redirects,
// pairing each registered memory word with its PC in the IF/ID register.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BOOT_CYCLES = 2,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_e state;
  logic [3:0]   boot_cnt;
  logic [31:0]  fetch_pc;
  logic [31:0]  a1_pc;     // address whose word arrives on imem_data_i next
  logic         a1_v;

  logic         run;
  logic         redirect;
  logic         hold;
  logic         advance;
  logic [31:0]  redirect_pc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    run         = (state == RUN);
    redirect    = 1'b0;
    hold        = 1'b0;
    advance     = 1'b0;
    redirect_pc = (jump_i ? jump_target_i : branch_target_i) & ~32'h3;
    imem_addr_o = RESET_PC;
    if (run) begin
      redirect    = jump_i || branch_taken_i;
      hold        = stall_i && !redirect;
      advance     = !stall_i && !redirect;
      // Re-reading a1 during a stall keeps imem_data_i matched to a1_pc.
      imem_addr_o = stall_i ? a1_pc : fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
      fetch_pc <= RESET_PC;
      a1_pc    <= '0;
      a1_v     <= 1'b0;
      pc_o     <= '0;
      inst_o   <= INSN_NOP;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 1'b1;
          if (boot_cnt == BOOT_LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (redirect) begin
            // Squash both in-flight words; pc_o is left stale under valid_o=0.
            fetch_pc <= redirect_pc;
            a1_v     <= 1'b0;
            valid_o  <= 1'b0;
            inst_o   <= INSN_NOP;
          end else if (advance) begin
            pc_o     <= a1_pc;
            inst_o   <= imem_data_i;
            valid_o  <= a1_v;
            a1_pc    <= fetch_pc;
            a1_v     <= 1'b1;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .cnt (redirect_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hold),
    .cnt (stall_cnt_o)
  );

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a registered memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, jump_i, branch_taken_i;
  logic [31:0] jump_target_i, branch_target_i;
  logic [31:0] imem_data_i;
  logic [31:0] imem_addr_o, pc_o, inst_o;
  logic        valid_o;
  logic [15:0] redirect_cnt_o, stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .BOOT_CYCLES (2),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_data_i     (imem_data_i),
    .imem_addr_o     (imem_addr_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o),
    .redirect_cnt_o  (redirect_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous instruction memory: data after edge k is the word at the pre-edge address.
  always @(posedge clk) imem_data_i <= word_at(imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef enum logic [1:0] {IC_NONE, IC_WORD, IC_NOP} inst_chk_e;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] addr;   // imem_addr_o before the edge, with inputs applied
    logic        valid;  // outputs after the edge
    logic [31:0] pc;
    inst_chk_e   ic;
    logic [15:0] rcnt;
    logic [15:0] scnt;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic s, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input inst_chk_e ic,
                              input logic [15:0] rc, input logic [15:0] sc);
    vec_t t;
    t.stall = s; t.jump = j; t.jt = jt; t.br = b; t.bt = bt; t.addr = addr;
    t.valid = v; t.pc = pc; t.ic = ic; t.rcnt = rc; t.scnt = sc;
    return t;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      stall_i         = vecs[i].stall;
      jump_i          = vecs[i].jump;
      jump_target_i   = vecs[i].jt;
      branch_taken_i  = vecs[i].br;
      branch_target_i = vecs[i].bt;
      #1;
      check($sformatf("v%0d addr", i), imem_addr_o, vecs[i].addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), {31'b0, valid_o}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) check($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
      if (vecs[i].ic == IC_WORD) check($sformatf("v%0d inst", i), inst_o, word_at(vecs[i].pc));
      if (vecs[i].ic == IC_NOP)  check($sformatf("v%0d inst_nop", i), inst_o, 32'h0);
      check($sformatf("v%0d redirect_cnt", i), {16'b0, redirect_cnt_o}, {16'b0, vecs[i].rcnt});
      check($sformatf("v%0d stall_cnt", i), {16'b0, stall_cnt_o}, {16'b0, vecs[i].scnt});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " valid"}, {31'b0, valid_o}, 32'h0);
    check({tag, " pc"}, pc_o, 32'h0);
    check({tag, " inst"}, inst_o, 32'h0);
    check({tag, " addr"}, imem_addr_o, 32'h0);
    check({tag, " redirect_cnt"}, {16'b0, redirect_cnt_o}, 32'h0);
    check({tag, " stall_cnt"}, {16'b0, stall_cnt_o}, 32'h0);
  endtask

  initial begin
    //               stl jmp jt            br  bt           addr          v  pc            ic       rc  sc
    vecs[0]  = mk(0, 0, 0,            0, 0,          32'h0,        0, 0,            IC_NONE, 0, 0);
    vecs[1]  = mk(1, 1, 32'h500,      0, 0,          32'h0,        0, 0,            IC_NONE, 0, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0,          32'h0,        0, 0,            IC_NONE, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 0,          32'h4,        1, 32'h0,        IC_WORD, 0, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0,          32'h8,        1, 32'h4,        IC_WORD, 0, 0);
    vecs[5]  = mk(0, 0, 0,            0, 0,          32'hC,        1, 32'h8,        IC_WORD, 0, 0);
    vecs[6]  = mk(0, 0, 0,            0, 0,          32'h10,       1, 32'hC,        IC_WORD, 0, 0);
    vecs[7]  = mk(0, 0, 0,            0, 0,          32'h14,       1, 32'h10,       IC_WORD, 0, 0);
    vecs[8]  = mk(1, 0, 0,            0, 0,          32'h14,       1, 32'h10,       IC_WORD, 0, 1);
    vecs[9]  = mk(1, 0, 0,            0, 0,          32'h14,       1, 32'h10,       IC_WORD, 0, 2);
    vecs[10] = mk(1, 0, 0,            0, 0,          32'h14,       1, 32'h10,       IC_WORD, 0, 3);
    vecs[11] = mk(0, 0, 0,            0, 0,          32'h18,       1, 32'h14,       IC_WORD, 0, 3);
    vecs[12] = mk(0, 1, 32'h100,      0, 0,          32'h1C,       0, 0,            IC_NOP,  1, 3);
    vecs[13] = mk(0, 0, 0,            0, 0,          32'h100,      0, 0,            IC_NONE, 1, 3);
    vecs[14] = mk(0, 0, 0,            0, 0,          32'h104,      1, 32'h100,      IC_WORD, 1, 3);
    vecs[15] = mk(1, 1, 32'h200,      1, 32'h300,    32'h104,      0, 0,            IC_NOP,  2, 3);
    vecs[16] = mk(0, 0, 0,            0, 0,          32'h200,      0, 0,            IC_NONE, 2, 3);
    vecs[17] = mk(0, 0, 0,            0, 0,          32'h204,      1, 32'h200,      IC_WORD, 2, 3);
    vecs[18] = mk(0, 0, 0,            1, 32'h303,    32'h208,      0, 0,            IC_NOP,  3, 3);
    vecs[19] = mk(0, 0, 0,            0, 0,          32'h300,      0, 0,            IC_NONE, 3, 3);
    vecs[20] = mk(0, 0, 0,            0, 0,          32'h304,      1, 32'h300,      IC_WORD, 3, 3);
    vecs[21] = mk(0, 1, 32'hFFFF_FFF8, 0, 0,         32'h308,      0, 0,            IC_NOP,  4, 3);
    vecs[22] = mk(0, 0, 0,            0, 0,          32'hFFFF_FFF8, 0, 0,           IC_NONE, 4, 3);
    vecs[23] = mk(0, 0, 0,            0, 0,          32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, IC_WORD, 4, 3);
    vecs[24] = mk(0, 0, 0,            0, 0,          32'h0,        1, 32'hFFFF_FFFC, IC_WORD, 4, 3);
    vecs[25] = mk(0, 0, 0,            0, 0,          32'h4,        1, 32'h0,        IC_WORD, 4, 3);
    vecs[26] = mk(1, 0, 0,            1, 32'h40,     32'h4,        0, 0,            IC_NOP,  5, 3);
    vecs[27] = mk(0, 0, 0,            0, 0,          32'h40,       0, 0,            IC_NONE, 5, 3);
    vecs[28] = mk(0, 0, 0,            0, 0,          32'h44,       1, 32'h40,       IC_WORD, 5, 3);

    rst = 1'b0;
    stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
    jump_target_i = '0; branch_target_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;

    // Boot, stall, jump, priority, alignment, wrap, branch-over-stall.
    run_vecs(0, 28);

    // Asynchronous reset between edges with a stall and a jump pending.
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h800;
    #3;
    rst = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    stall_i = 1'b0; jump_i = 1'b0; jump_target_i = '0;
    rst = 1'b1;
    run_vecs(0, 7);

    // Continuous redirects drive the redirect counter into saturation.
    jump_i = 1'b1; jump_target_i = 32'h1000;
    for (int i = 1; i <= 65541; i++) begin
      @(posedge clk);
      #1;
      if (i == 65534) check("redirect_cnt_pre_sat", {16'b0, redirect_cnt_o}, 32'h0000_FFFE);
      if (i == 65535) check("redirect_cnt_at_sat", {16'b0, redirect_cnt_o}, 32'h0000_FFFF);
    end
    check("redirect_cnt_held", {16'b0, redirect_cnt_o}, 32'h0000_FFFF);
    check("redirect_storm_valid", {31'b0, valid_o}, 32'h0);
    check("redirect_storm_stall_cnt", {16'b0, stall_cnt_o}, 32'h0);
    jump_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fetch_sequencer
